// File: rtl/adc_meas_filter.sv
// adc_meas_filter: per-channel boxcar averaging of AD7324 frames plus debounced
// over-voltage (ch0) and over-current (ch3) fault detection.
// Optional build macro ADC_FAULT_LATCH_EN: tripped faults hold until fault_clr
// instead of self-clearing on the next in-limit sample.
module adc_meas_filter #(
  parameter int unsigned AVG_LOG2  = 3,
  parameter int unsigned DATA_W    = 13,
  parameter int unsigned FAULT_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  input  logic [15:0]       frame_data,
  input  logic [DATA_W-1:0] vout_lim,
  input  logic [DATA_W-1:0] iout_lim,
  input  logic              fault_clr,
  output logic [DATA_W-1:0] vout_avg,
  output logic [DATA_W-1:0] temp_avg,
  output logic [DATA_W-1:0] vin_avg,
  output logic [DATA_W-1:0] iout_avg,
  output logic [3:0]        avg_valid,
  output logic              ovp,
  output logic              ocp
);

  typedef enum logic [1:0] {IDLE, COUNT, TRIP} fstate_t;

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  // Counter keeps at least one bit so AVG_LOG2 = 0 (pass-through) stays legal.
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned FC_W  = $clog2(FAULT_CNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [1:0]        ch;
  logic [DATA_W-1:0] data;
  logic [ACC_W-1:0]  sum;

  logic [ACC_W-1:0]  acc  [4];
  logic [CNT_W-1:0]  scnt [4];
  logic [DATA_W-1:0] avg  [4];
  logic [3:0]        valid_r;

  fstate_t           fstate   [2];
  fstate_t           fstate_n [2];
  logic [FC_W-1:0]   fcnt     [2];
  logic [FC_W-1:0]   fcnt_n   [2];
  logic              fhit     [2];
  logic              fover    [2];

  assign ch   = frame_data[14:13];
  assign data = frame_data[DATA_W-1:0];

`ifdef ADC_FAULT_LATCH_EN
  logic unused_msb;
  assign unused_msb = frame_data[15];
`else
  logic [1:0] unused_bits;
  assign unused_bits = {frame_data[15], fault_clr};
`endif

  // Running sum for the channel addressed by the current frame.
  always_comb begin
    sum = acc[ch] + ACC_W'(data);
  end

  // Accumulate samples; on the last sample of a window publish the average and strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        acc[i]  <= '0;
        scnt[i] <= '0;
        avg[i]  <= '0;
      end
      valid_r <= '0;
    end else begin
      valid_r <= '0;
      if (frame_valid) begin
        if (scnt[ch] == LAST) begin
          avg[ch]     <= DATA_W'(sum >> AVG_LOG2);
          acc[ch]     <= '0;
          scnt[ch]    <= '0;
          valid_r[ch] <= 1'b1;
        end else begin
          acc[ch]  <= sum;
          scnt[ch] <= scnt[ch] + CNT_W'(1);
        end
      end
    end
  end

  // Fault next-state: index 0 watches ch0 against vout_lim, index 1 watches ch3 against iout_lim.
  // An over-limit sample takes priority over a coincident fault_clr, except in TRIP.
  always_comb begin
    fhit[0]  = frame_valid && (ch == 2'd0);
    fover[0] = data > vout_lim;
    fhit[1]  = frame_valid && (ch == 2'd3);
    fover[1] = data > iout_lim;
    for (int unsigned i = 0; i < 2; i++) begin
      fstate_n[i] = fstate[i];
      fcnt_n[i]   = fcnt[i];
      case (fstate[i])
        COUNT: begin
          if (fhit[i] && fover[i]) begin
            fcnt_n[i] = fcnt[i] + FC_W'(1);
            if ((fcnt[i] + FC_W'(1)) == FC_W'(FAULT_CNT)) fstate_n[i] = TRIP;
          end else if (fhit[i]) begin
            fcnt_n[i]   = '0;
            fstate_n[i] = IDLE;
          end
`ifdef ADC_FAULT_LATCH_EN
          else if (fault_clr) begin
            fcnt_n[i]   = '0;
            fstate_n[i] = IDLE;
          end
`endif
        end
        TRIP: begin
`ifdef ADC_FAULT_LATCH_EN
          if (fault_clr) begin
            fcnt_n[i]   = '0;
            fstate_n[i] = IDLE;
          end
`else
          if (fhit[i] && !fover[i]) begin
            fcnt_n[i]   = '0;
            fstate_n[i] = IDLE;
          end
`endif
        end
        default: begin
          if (fhit[i] && fover[i]) begin
            fcnt_n[i]   = FC_W'(1);
            fstate_n[i] = (FAULT_CNT == 1) ? TRIP : COUNT;
          end
`ifdef ADC_FAULT_LATCH_EN
          else if (fault_clr) begin
            fcnt_n[i] = '0;
          end
`endif
        end
      endcase
    end
  end

  // Fault state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fstate[i] <= IDLE;
        fcnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        fstate[i] <= fstate_n[i];
        fcnt[i]   <= fcnt_n[i];
      end
    end
  end

  assign vout_avg  = avg[0];
  assign temp_avg  = avg[1];
  assign vin_avg   = avg[2];
  assign iout_avg  = avg[3];
  assign avg_valid = valid_r;
  assign ovp       = (fstate[0] == TRIP);
  assign ocp       = (fstate[1] == TRIP);

endmodule

// File: tb/tb_adc_meas_filter.sv
// Scoreboard bench for adc_meas_filter: expected averages are queued as frames are
// issued and popped by a monitor on each avg_valid strobe; fault outputs are checked
// directly after each frame.
module tb_adc_meas_filter;

  typedef struct {
    logic [1:0]  ch;
    logic [12:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic [15:0] frame_data = '0;
  logic [12:0] vout_lim = 13'd8191;
  logic [12:0] iout_lim = 13'd8191;
  logic        fault_clr = 1'b0;
  logic [12:0] vout_avg, temp_avg, vin_avg, iout_avg;
  logic [3:0]  avg_valid;
  logic        ovp, ocp;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  adc_meas_filter #(.AVG_LOG2(3), .DATA_W(13), .FAULT_CNT(4)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .vout_lim(vout_lim), .iout_lim(iout_lim), .fault_clr(fault_clr),
    .vout_avg(vout_avg), .temp_avg(temp_avg), .vin_avg(vin_avg), .iout_avg(iout_avg),
    .avg_valid(avg_valid), .ovp(ovp), .ocp(ocp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [12:0] avg_of(input int unsigned c);
    case (c)
      0: return vout_avg;
      1: return temp_avg;
      2: return vin_avg;
      default: return iout_avg;
    endcase
  endfunction

  // Bit 15 is driven high to show it is ignored.
  task automatic send(input logic [1:0] c, input logic [12:0] d, input logic clr = 1'b0);
    frame_valid = 1'b1;
    frame_data  = {1'b1, c, d};
    fault_clr   = clr;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    fault_clr   = 1'b0;
  endtask

  task automatic push(input logic [1:0] c, input logic [12:0] v);
    exp_t e;
    e.ch  = c;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobed channel must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (avg_valid[i]) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_strobe: got avg_valid[%0d]=1 value %0d expected no strobe", i, avg_of(i));
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("strobe_channel", i, e.ch);
            chk("avg_value", avg_of(i), e.val);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #1;
    chk("reset_vout", vout_avg, 0);
    chk("reset_valid", avg_valid, 0);
    chk("reset_ovp", ovp, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // 8 frames ch0 100..107 -> 103
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(2'd0, 13'd103);
      send(2'd0, 13'(100 + i));
    end
    repeat (2) @(posedge clk);
    #1;
    chk("vout_avg_hold", vout_avg, 103);

    // Interleaved ch1=4095 and ch2=0, back-to-back
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(2'd1, 13'd4095);
      send(2'd1, 13'd4095);
      if (i == 7) push(2'd2, 13'd0);
      send(2'd2, 13'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("temp_avg", temp_avg, 4095);
    chk("vin_avg", vin_avg, 0);
    chk("vout_unchanged", vout_avg, 103);
    chk("iout_unchanged", iout_avg, 0);

    // Asynchronous mid-sim reset, away from any clock edge
    send(2'd1, 13'd77);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vout", vout_avg, 0);
    chk("async_rst_temp", temp_avg, 0);
    chk("async_rst_valid", avg_valid, 0);
    chk("async_rst_ovp", ovp, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // OVP debounce: equal to limit is not over-limit; 4 consecutive trips
    vout_lim = 13'd2000;
    begin
      logic [12:0] seq [9];
      logic        exp_ovp [9];
      seq = '{13'd2001, 13'd2001, 13'd2001, 13'd1999, 13'd2000, 13'd2001, 13'd2001, 13'd2001, 13'd2001};
      exp_ovp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 9; i++) begin
        if (i == 7) push(2'd0, 13'd2000);
        send(2'd0, seq[i]);
        chk("ovp_debounce", ovp, exp_ovp[i]);
      end
    end
    // Other channel frames leave the tripped state alone
    send(2'd1, 13'd10);
    chk("ovp_other_ch", ovp, 1);

`ifdef ADC_FAULT_LATCH_EN
    send(2'd0, 13'd100);
    chk("ovp_latched", ovp, 1);
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
    chk("ovp_cleared", ovp, 0);
    for (int i = 0; i < 3; i++) begin
      send(2'd0, 13'd2001);
      chk("ovp_rearm", ovp, 0);
    end
    send(2'd0, 13'd2001, 1'b1);
    chk("ovp_trip_beats_clr", ovp, 1);
`else
    send(2'd0, 13'd2001);
    chk("ovp_stay_trip", ovp, 1);
    send(2'd0, 13'd100);
    chk("ovp_self_clear", ovp, 0);
`endif

    // OCP trip, reset discards partial sums, then a clean 8-sample window
    vout_lim = 13'd8191;
    iout_lim = 13'd800;
    for (int i = 0; i < 5; i++) begin
      send(2'd3, 13'd900);
      chk("ocp_debounce", ocp, (i >= 3) ? 1 : 0);
    end
    do_reset();
    chk("ocp_after_rst", ocp, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(2'd3, 13'd50);
      send(2'd3, 13'd50);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("iout_avg", iout_avg, 50);
    chk("ocp_in_limit", ocp, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
